// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte type, engine state encoding
// and a helper that decides which substitution widths are supported.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only widths that divide the 16-byte state into a whole number of passes.
    function automatic bit bpc_is_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
    endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Input and output valid/ready streams of the iterative SubBytes engine.
// master = the surrounding logic (producer and consumer), slave = the engine.
interface sub_bytes_iter_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] data_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] data_out;

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational 256-entry lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    // Entry 0x00 sits in the most significant byte, entry 0xFF in the least.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry i lives at bit offset (255 - i) * 8, and 255 - i is simply ~i.
    assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative forward SubBytes: accepts a 128-bit state, pushes BYTES_PER_CYCLE
// bytes per clock through a shared S-box bank while rotating the state, and
// presents the fully substituted state once every byte is back in place.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
)
(
    input  logic             clk,
    input  logic             rst,
    sub_bytes_iter_if.slave  bus
);

    localparam int K     = AES_BYTES / BYTES_PER_CYCLE;
    localparam int SUB_W = 8 * BYTES_PER_CYCLE;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

    genvar gi;

    generate
        if (!bpc_is_legal(BYTES_PER_CYCLE)) begin : g_bad_bpc
            $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic [AES_STATE_W-1:0] work_reg;
    logic [AES_STATE_W-1:0] work_next;
    logic [AES_STATE_W-1:0] work_rot;
    logic [AES_STATE_W-1:0] data_out_reg;
    logic [SUB_W-1:0]       sub_bytes;

    logic in_ready_int;
    logic out_valid_int;
    logic accept;
    logic shift_en;

    // S-box bank: the top bytes of the working register, in order.
    generate
        for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .in_byte  (work_reg[AES_STATE_W-1-8*gi -: 8]),
                .out_byte (sub_bytes[SUB_W-1-8*gi -: 8])
            );
        end
    endgenerate

    // Rotate left by one pass; substituted bytes re-enter at the bottom.
    generate
        if (BYTES_PER_CYCLE == AES_BYTES) begin : g_rot_full
            assign work_rot = sub_bytes;
        end else begin : g_rot_part
            assign work_rot = {work_reg[AES_STATE_W-SUB_W-1:0], sub_bytes};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> BUSY on accept, BUSY -> DONE after K passes,
    // DONE -> IDLE when the result is taken.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.in_valid)        state_next = BUSY;
            BUSY: if (cnt_reg == LAST_CNT) state_next = DONE;
            DONE: if (bus.out_ready)       state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Output decode; in_ready is forced low while reset is applied.
    always_comb begin
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
        shift_en      = 1'b0;
        case (state_reg)
            IDLE:    in_ready_int  = ~rst;
            BUSY:    shift_en      = 1'b1;
            DONE:    out_valid_int = 1'b1;
            default: in_ready_int  = 1'b0;
        endcase
    end

    assign accept = bus.in_valid & in_ready_int;

    // Datapath next values: load on accept, rotate-and-substitute while busy.
    always_comb begin
        work_next = work_reg;
        cnt_next  = cnt_reg;
        if (accept) begin
            work_next = bus.data_in;
            cnt_next  = '0;
        end else if (shift_en) begin
            work_next = work_rot;
            cnt_next  = cnt_reg + CNT_W'(1);
        end
    end

    // Datapath registers; data_out follows the working register's next value
    // so it already holds the final state in the first DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            work_reg     <= '0;
            data_out_reg <= '0;
        end else begin
            cnt_reg      <= cnt_next;
            work_reg     <= work_next;
            data_out_reg <= work_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.data_out  = data_out_reg;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: directed tests on the default-width engine, then
// randomized blocks on engines with 1, 2, 8 and 16 bytes per cycle, all
// compared against an S-box derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   sweep_go = 1'b0;

    logic [7:0] ref_tab [256];

    always #5 clk = ~clk;

    // Default-width engine used by the directed tests.
    sub_bytes_iter_if m_if ();

    sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gf_mul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state_ref(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = ref_tab[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int bpc_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One block through the default engine with in_valid held high (and
    // data_in churning) after acceptance, plus 'stall' cycles of backpressure.
    task automatic main_block(input logic [127:0] din, input int stall, input string tag,
                              output logic [127:0] got);
        logic [127:0] exp;
        int lat;
        exp = sub_state_ref(din);
        @(negedge clk);
        check_val({tag, "_in_ready_idle"}, 128'(m_if.in_ready), 128'(1));
        m_if.in_valid  = 1'b1;
        m_if.data_in   = din;
        m_if.out_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            m_if.data_in = rand128();
        end while (!m_if.out_valid && lat < 40);
        check_val({tag, "_latency"}, 128'(lat), 128'(5));
        check_val({tag, "_data"}, m_if.data_out, exp);
        check_val({tag, "_in_ready_done"}, 128'(m_if.in_ready), 128'(0));
        got = m_if.data_out;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            m_if.data_in = rand128();
            check_val({tag, "_hold_valid"}, 128'(m_if.out_valid), 128'(1));
            check_val({tag, "_hold_data"}, m_if.data_out, exp);
            check_val({tag, "_hold_in_ready"}, 128'(m_if.in_ready), 128'(0));
        end
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        @(negedge clk);
        m_if.out_ready = 1'b0;
        check_val({tag, "_in_ready_after"}, 128'(m_if.in_ready), 128'(1));
        check_val({tag, "_valid_after"}, 128'(m_if.out_valid), 128'(0));
        $display("[TB] bpc=4 %s in=%h out=%h lat=%0d stall=%0d", tag, din, got, lat, stall);
    endtask

    // ---------------- parameter sweep engines ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sweep
            localparam int P = bpc_of(gi);
            localparam int K = 16 / P;

            sub_bytes_iter_if sif ();
            bit done = 1'b0;

            sub_bytes_iter #(.BYTES_PER_CYCLE(P)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (sif)
            );

            // 500 random blocks with random gaps and random output stalls.
            initial begin
                logic [127:0] din;
                logic [127:0] exp;
                int lat;
                int stall;
                sif.in_valid  = 1'b0;
                sif.data_in   = '0;
                sif.out_ready = 1'b0;
                wait (sweep_go);
                for (int n = 0; n < 500; n++) begin
                    din   = rand128();
                    exp   = sub_state_ref(din);
                    stall = $urandom_range(0, 2);
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    check_val($sformatf("bpc%0d_in_ready", P), 128'(sif.in_ready), 128'(1));
                    sif.in_valid = 1'b1;
                    sif.data_in  = din;
                    lat = 0;
                    do begin
                        @(negedge clk);
                        lat++;
                        sif.data_in = rand128();
                    end while (!sif.out_valid && lat < 40);
                    check_val($sformatf("bpc%0d_latency", P), 128'(lat), 128'(K + 1));
                    check_val($sformatf("bpc%0d_data", P), sif.data_out, exp);
                    for (int s = 0; s < stall; s++) begin
                        @(negedge clk);
                        check_val($sformatf("bpc%0d_hold", P), sif.data_out, exp);
                    end
                    sif.in_valid  = 1'b0;
                    sif.out_ready = 1'b1;
                    @(negedge clk);
                    sif.out_ready = 1'b0;
                    check_val($sformatf("bpc%0d_released", P), 128'(sif.out_valid), 128'(0));
                    $display("[TB] bpc=%0d blk=%0d in=%h out=%h lat=%0d", P, n, din, sif.data_out, lat);
                end
                done = 1'b1;
            end
        end
    endgenerate

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] got;
        logic [127:0] din;
        bit seen;
        int waited;

        for (int i = 0; i < 256; i++) ref_tab[i] = sbox_model(8'(i));

        m_if.in_valid  = 1'b0;
        m_if.data_in   = '0;
        m_if.out_ready = 1'b0;

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_val("rst_out_valid", 128'(m_if.out_valid), 128'(0));
            check_val("rst_data_out", m_if.data_out, 128'(0));
            check_val("rst_in_ready", 128'(m_if.in_ready), 128'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", 128'(m_if.in_ready), 128'(1));
        $display("[TB] reset released");

        // Known-answer and byte-mapping vectors.
        main_block(128'h000102030405060708090a0b0c0d0e0f, 0, "kat", got);
        check_val("kat_const", got, 128'h637c777bf26b6fc53001672bfed7ab76);
        main_block({16{8'h00}}, 0, "zeros", got);
        check_val("zeros_const", got, {16{8'h63}});
        main_block({16{8'hff}}, 0, "ones", got);
        check_val("ones_const", got, {16{8'h16}});
        main_block(128'h53000000000000000000000000000000, 0, "b53", got);
        check_val("b53_const", got, 128'hed636363636363636363636363636363);

        // Backpressure for 10 cycles.
        main_block(rand128(), 10, "backpressure", got);

        // Reset in the second BUSY cycle aborts the block.
        din = rand128();
        @(negedge clk);
        m_if.in_valid = 1'b1;
        m_if.data_in  = din;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_out_valid", 128'(m_if.out_valid), 128'(0));
        check_val("abort_in_ready_in_rst", 128'(m_if.in_ready), 128'(0));
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (m_if.out_valid) seen = 1'b1;
        end
        check_val("abort_no_result", 128'(seen), 128'(0));
        $display("[TB] bpc=4 abort in=%h", din);
        main_block(128'h000102030405060708090a0b0c0d0e0f, 0, "post_abort", got);
        check_val("post_abort_const", got, 128'h637c777bf26b6fc53001672bfed7ab76);

        // A handful of random blocks on the default engine.
        for (int n = 0; n < 30; n++) begin
            main_block(rand128(), $urandom_range(0, 3), $sformatf("rand%0d", n), got);
        end

        // Parameter sweep, bounded wait for all engines.
        sweep_go = 1'b1;
        waited = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
               && waited < 60000) begin
            @(negedge clk);
            waited++;
        end
        check_val("sweep_finished",
                  128'({g_sweep[3].done, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}),
                  128'(4'hf));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
